// File: rtl/consumer_display.sv
// Consumer stage: binary-to-BCD conversion of buffered words (sequential double-dabble)
// and time-multiplexed drive of an 8-digit active-low seven-segment display.
module consumer_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int DATA_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        module_sig,
  input  logic [2:0]        prog,
  output logic              busy,
  output logic [7:0]        an,
  output logic [7:0]        dec_ddp,
  output logic [1:0]        fsm_state
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] R_MAX = RW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shift_r;
  logic [19:0]       bcd_r;
  logic [19:0]       disp_r;
  logic [3:0]        cnt;
  logic              pend_full;
  logic [DATA_W-1:0] pend_r;
  logic [19:0]       bcd_adj;

  logic [RW-1:0]     rcnt;
  logic [2:0]        idx;
  logic [3:0]        dig [8];
  logic [7:0]        vis;
  logic [7:0]        seg_next;

  assign busy      = (state != IDLE);
  assign fsm_state = state;

  // Add-3 correction applied to every nibble before the shift of each iteration.
  always_comb begin
    bcd_adj = bcd_r;
    for (int i = 0; i < 5; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift_r   <= '0;
      bcd_r     <= '0;
      disp_r    <= '0;
      cnt       <= '0;
      pend_full <= 1'b0;
      pend_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (data_valid) begin
            shift_r <= data_in;
            bcd_r   <= '0;
            cnt     <= '0;
            state   <= CONV;
          end
        end
        CONV: begin
          bcd_r   <= {bcd_adj[18:0], shift_r[DATA_W-1]};
          shift_r <= {shift_r[DATA_W-2:0], 1'b0};
          cnt     <= cnt + 4'd1;
          if (cnt == 4'd15) state <= DONE;
          // Newest strobe wins; anything it overwrites is dropped.
          if (data_valid) begin
            pend_r    <= data_in;
            pend_full <= 1'b1;
          end
        end
        DONE: begin
          disp_r <= bcd_r;
          if (data_valid) begin
            shift_r   <= data_in;
            bcd_r     <= '0;
            cnt       <= '0;
            pend_full <= 1'b0;
            state     <= CONV;
          end else if (pend_full) begin
            shift_r   <= pend_r;
            bcd_r     <= '0;
            cnt       <= '0;
            pend_full <= 1'b0;
            state     <= CONV;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 8'h03;
      4'd1:    seg_of = 8'h9F;
      4'd2:    seg_of = 8'h25;
      4'd3:    seg_of = 8'h0D;
      4'd4:    seg_of = 8'h99;
      4'd5:    seg_of = 8'h49;
      4'd6:    seg_of = 8'h41;
      4'd7:    seg_of = 8'h1F;
      4'd8:    seg_of = 8'h01;
      4'd9:    seg_of = 8'h09;
      default: seg_of = 8'hFF;
    endcase
  endfunction

  // A BCD digit is lit when it or any more significant digit is non-zero; units always lit.
  always_comb begin
    for (int i = 0; i < 8; i++) dig[i] = 4'd0;
    for (int i = 0; i < 5; i++) dig[i] = disp_r[4*i +: 4];
    vis    = 8'h00;
    vis[4] = (disp_r[19:16] != 4'd0);
    vis[3] = vis[4] | (disp_r[15:12] != 4'd0);
    vis[2] = vis[3] | (disp_r[11:8] != 4'd0);
    vis[1] = vis[2] | (disp_r[7:4] != 4'd0);
    vis[0] = 1'b1;
  end

  always_comb begin
    seg_next = 8'hFF;
    case (idx)
      3'd0, 3'd1, 3'd2, 3'd3, 3'd4: if (vis[idx]) seg_next = seg_of(dig[idx]);
      3'd6: seg_next = seg_of({1'b0, prog});
      3'd7: begin
        if (module_sig == 2'b01)      seg_next = 8'h71;
        else if (module_sig == 2'b11) seg_next = 8'hE1;
        else                          seg_next = 8'hFF;
      end
      default: seg_next = 8'hFF;
    endcase
  end

  // an and dec_ddp are registered from the same index, so they always switch together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rcnt    <= '0;
      idx     <= '0;
      an      <= 8'hFF;
      dec_ddp <= 8'hFF;
    end else begin
      an      <= ~(8'd1 << idx);
      dec_ddp <= seg_next;
      if (rcnt == R_MAX) begin
        rcnt <= '0;
        idx  <= idx + 3'd1;
      end else begin
        rcnt <= rcnt + RW'(1);
      end
    end
  end

endmodule

// File: tb/tb_consumer_display.sv
// Bench for consumer_display: per-cycle expected {busy, an, dec_ddp} frames from a
// time-based reference model, checked by an independent negedge monitor.
module tb_consumer_display;

  localparam int DIV = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        data_valid = 1'b0;
  logic [15:0] data_in = 16'd0;
  logic [1:0]  module_sig = 2'b00;
  logic [2:0]  prog = 3'd0;
  logic        busy;
  logic [7:0]  an;
  logic [7:0]  dec_ddp;
  logic [1:0]  fsm_state;

  consumer_display #(.REFRESH_DIV(DIV), .DATA_W(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .data_valid (data_valid),
    .data_in    (data_in),
    .module_sig (module_sig),
    .prog       (prog),
    .busy       (busy),
    .an         (an),
    .dec_ddp    (dec_ddp),
    .fsm_state  (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 5000000", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [7:0] seg_tab [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                               8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};
  localparam logic [16:0] RST_FRAME = {1'b0, 8'hFF, 8'hFF};

  logic [16:0] exp_q [$];
  int    n_cmp = 0;
  int    n_err = 0;
  string phase = "reset";

  int edge_n, scan_t, disp_val, job_val, commit_at, pend_val;
  bit active, pend_ok;

  function automatic logic [7:0] exp_digit(input int i, input int val,
                                           input logic [1:0] ms, input logic [2:0] pg);
    int p;
    if (i <= 4) begin
      p = 10 ** i;
      if (i > 0 && val < p) return 8'hFF;
      return seg_tab[(val / p) % 10];
    end
    if (i == 5) return 8'hFF;
    if (i == 6) return seg_tab[pg];
    if (ms == 2'b01) return 8'h71;
    if (ms == 2'b11) return 8'hE1;
    return 8'hFF;
  endfunction

  // A word takes 17 edges from the edge that accepts it to the edge that shows it.
  task automatic start_job(input int v);
    job_val   = v;
    commit_at = edge_n + 17;
    active    = 1'b1;
  endtask

  always @(posedge clock) begin
    int idx;
    logic [7:0] e_an, e_seg;
    if (!reset) begin
      edge_n   = 0;
      scan_t   = 0;
      disp_val = 0;
      active   = 1'b0;
      pend_ok  = 1'b0;
      exp_q.push_back(RST_FRAME);
    end else begin
      idx   = (scan_t / DIV) % 8;
      e_an  = ~(8'd1 << idx);
      e_seg = exp_digit(idx, disp_val, module_sig, prog);
      scan_t++;
      if (active && edge_n == commit_at) begin
        disp_val = job_val;
        if (data_valid) begin
          start_job(int'(data_in));
          pend_ok = 1'b0;
        end else if (pend_ok) begin
          start_job(pend_val);
          pend_ok = 1'b0;
        end else begin
          active = 1'b0;
        end
      end else if (active) begin
        if (data_valid) begin
          pend_ok  = 1'b1;
          pend_val = int'(data_in);
        end
      end else if (data_valid) begin
        start_job(int'(data_in));
      end
      exp_q.push_back({active, e_an, e_seg});
      edge_n++;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [16:0] got, exp;
    forever begin
      @(negedge clock);
      #1;
      got = {busy, an, dec_ddp};
      if (!reset) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        exp = RST_FRAME;
      end else if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s underflow: got busy=%b an=%h seg=%h required a queued frame",
                 phase, busy, an, dec_ddp);
        continue;
      end else begin
        exp = exp_q.pop_front();
      end
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s frame t=%0t: got busy=%b an=%h seg=%h (state %0d) required busy=%b an=%h seg=%h",
                 phase, $time, got[16], got[15:8], got[7:0], fsm_state,
                 exp[16], exp[15:8], exp[7:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic strobe(input logic [15:0] v);
    @(negedge clock);
    data_valid = 1'b1;
    data_in    = v;
    @(negedge clock);
    data_valid = 1'b0;
  endtask

  task automatic tick_random(input int n);
    repeat (n) begin
      @(negedge clock);
      if ($urandom_range(0, 7) == 0) module_sig = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) prog = 3'($urandom_range(0, 7));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] v;
    reset = 1'b0;
    prog  = 3'd3;
    tick(3);
    reset = 1'b1;

    phase = "reset_idle";
    tick(70);

    phase = "single_12345";
    strobe(16'd12345);
    tick(60);

    phase = "max_65535";
    strobe(16'd65535);
    tick(60);

    phase = "seven";
    strobe(16'd7);
    tick(60);

    phase = "zero";
    strobe(16'd0);
    tick(60);

    phase = "back_to_back";
    @(negedge clock); data_valid = 1'b1; data_in = 16'd100;
    @(negedge clock); data_valid = 1'b0;
    @(negedge clock);
    @(negedge clock); data_valid = 1'b1; data_in = 16'd200;
    @(negedge clock); data_valid = 1'b0;
    @(negedge clock); data_valid = 1'b1; data_in = 16'd300;
    @(negedge clock); data_valid = 1'b0;
    tick(80);

    phase = "labels";
    module_sig = 2'b01; tick(40);
    module_sig = 2'b11; tick(40);
    module_sig = 2'b10; tick(40);
    prog = 3'd5;        tick(40);
    module_sig = 2'b00;

    phase = "reset_mid";
    strobe(16'd9999);
    tick(7);
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(80);

    phase = "random";
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0:       v = 16'd65535;
        1:       v = 16'($urandom_range(0, 9));
        default: v = 16'($urandom_range(0, 65535));
      endcase
      strobe(v);
      tick_random($urandom_range(0, 25));
    end
    tick(80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
